// File: rtl/ctrl_conv2d_param_if.sv
// Handshake and address bus between the conv2d window sequencer and its user/MAC engine.
// The master side issues start, bases and done; the slave (the sequencer) drives addresses and status.
interface ctrl_conv2d_param_if #(
  parameter int AW = 14
);
  logic          start;
  logic [AW-1:0] pix_base_addr;
  logic [AW-1:0] kernel_base_addr;
  logic [AW-1:0] base_result_addr;
  logic          done;
  logic [AW-1:0] pix_addr;
  logic [AW-1:0] kernel_addr;
  logic [AW-1:0] result_addr;
  logic          en;
  logic          ack;
  logic          busy;
  logic          completed;

  modport master (
    output start, pix_base_addr, kernel_base_addr, base_result_addr, done,
    input  pix_addr, kernel_addr, result_addr, en, ack, busy, completed
  );

  modport slave (
    input  start, pix_base_addr, kernel_base_addr, base_result_addr, done,
    output pix_addr, kernel_addr, result_addr, en, ack, busy, completed
  );
endinterface

// File: rtl/ctrl_conv2d_param.sv
// Window sequencer for a parameterised 2-D convolution: walks col, row, channel and hands
// each window's pixel, kernel and result addresses to a MAC engine with an en/done/ack handshake.
module ctrl_conv2d_param #(
  parameter int IMG_W  = 48,
  parameter int IMG_H  = 48,
  parameter int K      = 3,
  parameter int STRIDE = 1,
  parameter int CH     = 1,
  parameter int AW     = 14
) (
  input  logic                 clk,
  input  logic                 rst,
  ctrl_conv2d_param_if.slave   bus
);

  localparam int OUT_W = (IMG_W - K) / STRIDE + 1;
  localparam int OUT_H = (IMG_H - K) / STRIDE + 1;

  localparam int COL_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int ROW_W = (OUT_H > 1) ? $clog2(OUT_H) : 1;
  localparam int CH_W  = (CH > 1)    ? $clog2(CH)    : 1;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(OUT_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(OUT_H - 1);
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(CH - 1);

  // Address steps; all address arithmetic wraps silently at 2^AW.
  localparam logic [AW-1:0] COL_STEP = AW'(STRIDE);
  localparam logic [AW-1:0] ROW_STEP = AW'(STRIDE * IMG_W);
  localparam logic [AW-1:0] CH_STEP  = AW'(IMG_W * IMG_H);
  localparam logic [AW-1:0] KER_STEP = AW'(K * K);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    ACK,
    FINISH
  } state_t;

  state_t            state_q;
  logic [COL_W-1:0]  col_q;
  logic [ROW_W-1:0]  row_q;
  logic [CH_W-1:0]   ch_q;

  // pix_q is the live window address; row_pix_q / ch_pix_q remember the start of the
  // current row and channel so wrapping needs only an add, never a multiply.
  logic [AW-1:0]     pix_q;
  logic [AW-1:0]     row_pix_q;
  logic [AW-1:0]     ch_pix_q;
  logic [AW-1:0]     ker_q;
  logic [AW-1:0]     res_q;

  logic              en_q;
  logic              ack_q;
  logic              busy_q;
  logic              completed_q;

  logic [AW-1:0]     row_pix_nxt;
  logic [AW-1:0]     ch_pix_nxt;

  assign row_pix_nxt = row_pix_q + ROW_STEP;
  assign ch_pix_nxt  = ch_pix_q + CH_STEP;

  always_ff @(posedge clk) begin
    // NOTE: reset is tested first so it wins over start/done in the same cycle; every
    // register, including the address registers, is cleared so outputs read 0 after reset.
    if (rst) begin
      state_q     <= IDLE;
      col_q       <= '0;
      row_q       <= '0;
      ch_q        <= '0;
      pix_q       <= '0;
      row_pix_q   <= '0;
      ch_pix_q    <= '0;
      ker_q       <= '0;
      res_q       <= '0;
      en_q        <= 1'b0;
      ack_q       <= 1'b0;
      busy_q      <= 1'b0;
      completed_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            col_q     <= '0;
            row_q     <= '0;
            ch_q      <= '0;
            pix_q     <= bus.pix_base_addr;
            row_pix_q <= bus.pix_base_addr;
            ch_pix_q  <= bus.pix_base_addr;
            ker_q     <= bus.kernel_base_addr;
            res_q     <= bus.base_result_addr;
            en_q      <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= ISSUE;
          end
        end

        ISSUE: begin
          if (bus.done) begin
            en_q    <= 1'b0;
            ack_q   <= 1'b1;
            state_q <= ACK;
          end
        end

        ACK: begin
          ack_q <= 1'b0;
          if (col_q != COL_LAST) begin
            col_q   <= col_q + COL_W'(1);
            pix_q   <= pix_q + COL_STEP;
            res_q   <= res_q + AW'(1);
            en_q    <= 1'b1;
            state_q <= ISSUE;
          end else if (row_q != ROW_LAST) begin
            col_q     <= '0;
            row_q     <= row_q + ROW_W'(1);
            row_pix_q <= row_pix_nxt;
            pix_q     <= row_pix_nxt;
            res_q     <= res_q + AW'(1);
            en_q      <= 1'b1;
            state_q   <= ISSUE;
          end else if (ch_q != CH_LAST) begin
            col_q     <= '0;
            row_q     <= '0;
            ch_q      <= ch_q + CH_W'(1);
            ch_pix_q  <= ch_pix_nxt;
            row_pix_q <= ch_pix_nxt;
            pix_q     <= ch_pix_nxt;
            ker_q     <= ker_q + KER_STEP;
            res_q     <= res_q + AW'(1);
            en_q      <= 1'b1;
            state_q   <= ISSUE;
          end else begin
            completed_q <= 1'b1;
            state_q     <= FINISH;
          end
        end

        FINISH: begin
          completed_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.pix_addr    = pix_q;
  assign bus.kernel_addr = ker_q;
  assign bus.result_addr = res_q;
  assign bus.en          = en_q;
  assign bus.ack         = ack_q;
  assign bus.busy        = busy_q;
  assign bus.completed   = completed_q;

endmodule

// File: tb/tb_ctrl_conv2d_param.sv
// Scoreboard bench for ctrl_conv2d_param: three geometries run side by side, expected windows
// come from the closed-form address equations and a monitor pops them as the DUTs handshake.
module tb_ctrl_conv2d_param;

  localparam int AW = 14;
  localparam int NI = 3;

  // Per-instance geometry: 0 = 6x5 K3 S1 CH1, 1 = 7x7 K3 S2 CH1, 2 = 6x5 K3 S1 CH2.
  localparam int GW [NI] = '{6, 7, 6};
  localparam int GH [NI] = '{5, 7, 5};
  localparam int GK [NI] = '{3, 3, 3};
  localparam int GS [NI] = '{1, 2, 1};
  localparam int GC [NI] = '{1, 1, 2};

  typedef struct packed {
    logic          en;
    logic          ack;
    logic          busy;
    logic          completed;
    logic [AW-1:0] pix;
    logic [AW-1:0] ker;
    logic [AW-1:0] res;
  } obs_t;

  typedef struct {
    bit            last;
    logic [AW-1:0] pix;
    logic [AW-1:0] ker;
    logic [AW-1:0] res;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  logic          start_v [NI];
  logic [AW-1:0] pb_v    [NI];
  logic [AW-1:0] kb_v    [NI];
  logic [AW-1:0] rb_v    [NI];
  logic          done_v  [NI];
  obs_t          obs     [NI];

  exp_t exp_q [NI][$];
  int   ack_cnt  [NI];
  int   done_cnt [NI];
  int   busy_cyc [NI];
  int   done_mode[NI];   // 0: done one cycle after en, 1: held high, 2: random delay
  int   dly      [NI];
  int   en_cnt   [NI];
  bit   prev_ack [NI];

  int n_cmp  = 0;
  int n_fail = 0;

  ctrl_conv2d_param_if #(.AW(AW)) if_a ();
  ctrl_conv2d_param_if #(.AW(AW)) if_b ();
  ctrl_conv2d_param_if #(.AW(AW)) if_c ();

  ctrl_conv2d_param #(.IMG_W(6), .IMG_H(5), .K(3), .STRIDE(1), .CH(1), .AW(AW)) u_a (
    .clk(clk), .rst(rst), .bus(if_a.slave)
  );
  ctrl_conv2d_param #(.IMG_W(7), .IMG_H(7), .K(3), .STRIDE(2), .CH(1), .AW(AW)) u_b (
    .clk(clk), .rst(rst), .bus(if_b.slave)
  );
  ctrl_conv2d_param #(.IMG_W(6), .IMG_H(5), .K(3), .STRIDE(1), .CH(2), .AW(AW)) u_c (
    .clk(clk), .rst(rst), .bus(if_c.slave)
  );

  assign if_a.start = start_v[0];
  assign if_a.pix_base_addr = pb_v[0];
  assign if_a.kernel_base_addr = kb_v[0];
  assign if_a.base_result_addr = rb_v[0];
  assign if_a.done = done_v[0];
  assign if_b.start = start_v[1];
  assign if_b.pix_base_addr = pb_v[1];
  assign if_b.kernel_base_addr = kb_v[1];
  assign if_b.base_result_addr = rb_v[1];
  assign if_b.done = done_v[1];
  assign if_c.start = start_v[2];
  assign if_c.pix_base_addr = pb_v[2];
  assign if_c.kernel_base_addr = kb_v[2];
  assign if_c.base_result_addr = rb_v[2];
  assign if_c.done = done_v[2];

  assign obs[0] = {if_a.en, if_a.ack, if_a.busy, if_a.completed, if_a.pix_addr, if_a.kernel_addr, if_a.result_addr};
  assign obs[1] = {if_b.en, if_b.ack, if_b.busy, if_b.completed, if_b.pix_addr, if_b.kernel_addr, if_b.result_addr};
  assign obs[2] = {if_c.en, if_c.ack, if_c.busy, if_c.completed, if_c.pix_addr, if_c.kernel_addr, if_c.result_addr};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: every window of a pass, straight from the address equations.
  task automatic push_pass(input int id, input int pb, input int kb, input int rb);
    int   ow;
    int   oh;
    exp_t e;
    ow = (GW[id] - GK[id]) / GS[id] + 1;
    oh = (GH[id] - GK[id]) / GS[id] + 1;
    for (int c = 0; c < GC[id]; c++)
      for (int r = 0; r < oh; r++)
        for (int x = 0; x < ow; x++) begin
          e.last = 1'b0;
          e.pix  = AW'(pb + c * GW[id] * GH[id] + r * GS[id] * GW[id] + x * GS[id]);
          e.ker  = AW'(kb + c * GK[id] * GK[id]);
          e.res  = AW'(rb + c * ow * oh + r * ow + x);
          exp_q[id].push_back(e);
        end
    e.last = 1'b1;
    e.pix  = '0;
    e.ker  = '0;
    e.res  = '0;
    exp_q[id].push_back(e);
  endtask

  task automatic start_pass(input int id, input int pb, input int kb, input int rb, input bit model);
    @(posedge clk); #1;
    pb_v[id]    = AW'(pb);
    kb_v[id]    = AW'(kb);
    rb_v[id]    = AW'(rb);
    start_v[id] = 1'b1;
    if (model) push_pass(id, pb, kb, rb);
    @(posedge clk); #1;
    start_v[id] = 1'b0;
  endtask

  task automatic wait_all(input string tag);
    int t;
    int pending;
    t = 0;
    pending = exp_q[0].size() + exp_q[1].size() + exp_q[2].size();
    while (pending != 0 && t < 4000) begin
      @(posedge clk);
      t++;
      pending = exp_q[0].size() + exp_q[1].size() + exp_q[2].size();
    end
    check({tag, "_pending"}, pending, 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Monitor then done responder, both sampled on the falling edge.
  always @(negedge clk) begin
    for (int id = 0; id < NI; id++) begin
      obs_t o;
      exp_t f;
      o = obs[id];
      if (o.en === 1'b1) begin
        if (exp_q[id].size() == 0 || exp_q[id][0].last) begin
          check($sformatf("unexpected_en[%0d]", id), 1, 0);
        end else begin
          f = exp_q[id][0];
          check($sformatf("pix[%0d]", id), o.pix, f.pix);
          check($sformatf("ker[%0d]", id), o.ker, f.ker);
          check($sformatf("res[%0d]", id), o.res, f.res);
        end
      end
      if (o.ack === 1'b1) begin
        check($sformatf("en_with_ack[%0d]", id), o.en, 0);
        if (exp_q[id].size() == 0 || exp_q[id][0].last) begin
          check($sformatf("unexpected_ack[%0d]", id), 1, 0);
        end else begin
          f = exp_q[id].pop_front();
          check($sformatf("ack_res[%0d]", id), o.res, f.res);
          ack_cnt[id]++;
        end
      end
      if (o.completed === 1'b1) begin
        if (exp_q[id].size() == 0 || !exp_q[id][0].last) begin
          check($sformatf("unexpected_completed[%0d]", id), 1, 0);
        end else begin
          void'(exp_q[id].pop_front());
          check($sformatf("completed_after_ack[%0d]", id), prev_ack[id], 1);
          done_cnt[id]++;
        end
      end
      if (o.en === 1'b1 || o.ack === 1'b1 || o.completed === 1'b1 || o.busy === 1'b1)
        check($sformatf("busy_state[%0d]", id), o.busy, o.en | o.ack | o.completed);
      if (o.busy === 1'b1) busy_cyc[id]++;
      prev_ack[id] = (o.ack === 1'b1);

      if (done_mode[id] == 1) begin
        done_v[id] = 1'b1;
      end else if (o.en === 1'b1) begin
        en_cnt[id]++;
        done_v[id] = (en_cnt[id] > dly[id]);
      end else begin
        en_cnt[id] = 0;
        done_v[id] = 1'b0;
        dly[id]    = (done_mode[id] == 2) ? int'($urandom_range(0, 3)) : 1;
      end
    end
  end

  initial begin
    int base_ack;
    int base_done;
    int t;
    bit got;

    rst = 1'b1;
    for (int i = 0; i < NI; i++) begin
      start_v[i] = 1'b0; pb_v[i] = '0; kb_v[i] = '0; rb_v[i] = '0; done_v[i] = 1'b0;
      ack_cnt[i] = 0; done_cnt[i] = 0; busy_cyc[i] = 0; done_mode[i] = 0;
      dly[i] = 1; en_cnt[i] = 0; prev_ack[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) check($sformatf("reset_outputs[%0d]", i), obs[i], 0);
    rst = 1'b0;

    // 6x5 K3 S1: 12 windows, done one cycle after en.
    start_pass(0, 100, 0, 500, 1);
    wait_all("basic");
    check("basic_acks", ack_cnt[0], 12);
    check("basic_completed", done_cnt[0], 1);

    // 7x7 K3 S2: 3x3 outputs.
    start_pass(1, 0, 0, 0, 1);
    wait_all("stride2");
    check("stride2_acks", ack_cnt[1], 9);

    // Two channels: second channel from 130, kernel 9, results 512..523.
    start_pass(2, 100, 0, 500, 1);
    wait_all("two_ch");
    check("two_ch_acks", ack_cnt[2], 24);
    check("two_ch_completed", done_cnt[2], 1);

    // done held high: two cycles per window plus FINISH; a start while busy must be ignored.
    done_mode[0] = 1;
    busy_cyc[0]  = 0;
    base_ack     = ack_cnt[0];
    start_pass(0, 200, 40, 1000, 1);
    repeat (3) @(posedge clk);
    start_pass(0, 9, 9, 9, 0);
    wait_all("held");
    check("held_busy_cycles", busy_cyc[0], 25);
    check("held_acks", ack_cnt[0] - base_ack, 12);
    done_mode[0] = 0;
    repeat (2) @(posedge clk);

    // start in the completed cycle is ignored.
    start_pass(0, 100, 0, 500, 1);
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(posedge clk); #1;
      if (obs[0].completed === 1'b1) got = 1'b1;
    end
    check("completed_seen", got, 1);
    if (got) begin
      start_v[0] = 1'b1;
      @(posedge clk); #1;
      start_v[0] = 1'b0;
    end
    repeat (4) @(posedge clk);
    #1;
    check("start_at_completed_busy", obs[0].busy, 0);

    // Reset after 5 windows, with start on instance 1 in the same cycle.
    base_ack  = ack_cnt[0];
    base_done = done_cnt[0];
    start_pass(0, 300, 7, 50, 1);
    t = 0;
    while (ack_cnt[0] < base_ack + 5 && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    check("rst_reach_window5", ack_cnt[0] - base_ack, 5);
    rst = 1'b1;
    start_v[1] = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < NI; i++) begin
      check($sformatf("rst_mid_outputs[%0d]", i), obs[i], 0);
      exp_q[i].delete();
    end
    @(posedge clk); #1;
    rst = 1'b0;
    start_v[1] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_no_completed", done_cnt[0], base_done);
    check("rst_start_ignored", obs[1].busy, 0);
    start_pass(0, 300, 7, 50, 1);
    wait_all("after_rst");

    // Address wrap at 2^14.
    start_pass(0, 16380, 16383, 16378, 1);
    wait_all("wrap");

    // Random bases and done latency on all three geometries concurrently.
    for (int i = 0; i < NI; i++) done_mode[i] = 2;
    for (int it = 0; it < 5; it++) begin
      for (int i = 0; i < NI; i++)
        start_pass(i, int'($urandom_range(0, 16383)), int'($urandom_range(0, 16383)),
                   int'($urandom_range(0, 16383)), 1);
      wait_all("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
